// File: rtl/alu_share_arbiter.sv
// Round-robin front end that lets two requesters share one external combinational ALU.
// Operations are accepted in IDLE, executed for one cycle, and returned on a one-hot response channel.
module alu_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [2*SEL_W-1:0]   req_sel,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_carry,
    output logic                 busy,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [SEL_W-1:0]     alu_sel,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               ptr_reg, ptr_next;
    logic               owner_reg, owner_next;
    logic               pending_reg, pending_next;
    logic [WIDTH-1:0]   alu_a_reg, alu_a_next;
    logic [WIDTH-1:0]   alu_b_reg, alu_b_next;
    logic [SEL_W-1:0]   alu_sel_reg, alu_sel_next;
    logic [WIDTH-1:0]   rsp_data_reg, rsp_data_next;
    logic               rsp_carry_reg, rsp_carry_next;

    logic [1:0]         grant;
    logic               winner;

    logic [WIDTH-1:0]   op_a   [2];
    logic [WIDTH-1:0]   op_b   [2];
    logic [SEL_W-1:0]   op_sel [2];

    // Unpack per-requester operands and build the one-hot response valid from owner.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign op_a[gi]      = req_a[gi*WIDTH +: WIDTH];
            assign op_b[gi]      = req_b[gi*WIDTH +: WIDTH];
            assign op_sel[gi]    = req_sel[gi*SEL_W +: SEL_W];
            assign rsp_valid[gi] = pending_reg & (owner_reg == 1'(gi));
        end
    endgenerate

    // Grant only in IDLE; with both requesting, the pointer names the preferred requester.
    always_comb begin
        grant = 2'b00;
        if (!rst && state_reg == IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_reg ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign winner    = grant[1];
    assign req_ready = grant;

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        owner_next     = owner_reg;
        pending_next   = pending_reg;
        alu_a_next     = alu_a_reg;
        alu_b_next     = alu_b_reg;
        alu_sel_next   = alu_sel_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_carry_next = rsp_carry_reg;

        case (state_reg)
            IDLE: begin
                if (|grant) begin
                    alu_a_next   = op_a[winner];
                    alu_b_next   = op_b[winner];
                    alu_sel_next = op_sel[winner];
                    owner_next   = winner;
                    ptr_next     = ~winner;
                    state_next   = EXEC;
                end
            end
            EXEC: begin
                // ALU inputs have been stable for a full cycle; sample its result now.
                rsp_data_next  = alu_out;
                rsp_carry_next = alu_carry;
                pending_next   = 1'b1;
                state_next     = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_reg]) begin
                    pending_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: begin
                pending_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= 1'b0;
            owner_reg     <= 1'b0;
            pending_reg   <= 1'b0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_sel_reg   <= '0;
            rsp_data_reg  <= '0;
            rsp_carry_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            owner_reg     <= owner_next;
            pending_reg   <= pending_next;
            alu_a_reg     <= alu_a_next;
            alu_b_reg     <= alu_b_next;
            alu_sel_reg   <= alu_sel_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_carry_reg <= rsp_carry_next;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_sel   = alu_sel_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_carry = rsp_carry_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (round-robin fairness, 2-cycle response latency, response hold).
`timescale 1ns/1ps
module tb_alu_share_arbiter;

    localparam int WIDTH = 8;
    localparam int SEL_W = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [2*WIDTH-1:0]   req_a;
    logic [2*WIDTH-1:0]   req_b;
    logic [2*SEL_W-1:0]   req_sel;
    logic [1:0]           rsp_valid;
    logic [1:0]           rsp_ready;
    logic [WIDTH-1:0]     rsp_data;
    logic                 rsp_carry;
    logic                 busy;
    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic [SEL_W-1:0]     alu_sel;
    logic [WIDTH-1:0]     alu_out;
    logic                 alu_carry;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Reference ALU behaviour: sel 0 = add with carry out, otherwise subtract (borrow in bit 8).
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        if (s == 4'h0) return {1'b0, a} + {1'b0, b};
        else           return {1'b0, a} - {1'b0, b};
    endfunction

    // External ALU attached to the DUT.
    logic [8:0] alu_full;
    assign alu_full  = alu_f(alu_a, alu_b, alu_sel);
    assign alu_out   = alu_full[7:0];
    assign alu_carry = alu_full[8];

    alu_share_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .busy      (busy),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        req_a[i*WIDTH +: WIDTH]   = a;
        req_b[i*WIDTH +: WIDTH]   = b;
        req_sel[i*SEL_W +: SEL_W] = s;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req_a = '0; req_b = '0; req_sel = '0;
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_carry, busy, alu_a, alu_b, alu_sel} !== '0) begin
            failures++;
            $display("FAIL reset_outputs rr=%b rv=%b d=%h c=%b busy=%b a=%h b=%h s=%h expected all 0",
                     req_ready, rsp_valid, rsp_data, rsp_carry, busy, alu_a, alu_b, alu_sel);
        end
        tick();
        rst = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_single();
        do_reset();
        set_op(0, 8'h0A, 8'h02, 4'h0);
        req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        set_op(0, 8'h55, 8'h66, 4'h1);
        @(negedge clk);
        checks++;
        if (alu_a !== 8'h0A || alu_b !== 8'h02 || busy !== 1'b1 || rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL single_exec a=%h b=%h busy=%b rv=%b exp a=0a b=02 busy=1 rv=00", alu_a, alu_b, busy, rsp_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 8'h0C || rsp_carry !== 1'b0) begin
            failures++;
            $display("FAIL single_resp rv=%b d=%h c=%b exp rv=01 d=0c c=0", rsp_valid, rsp_data, rsp_carry);
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_data !== 8'h0C) begin
            failures++;
            $display("FAIL single_done rv=%b busy=%b d=%h exp rv=00 busy=0 d=0c", rsp_valid, busy, rsp_data);
        end
        $display("test_single: a=0a b=02 -> d=%h c=%b", rsp_data, rsp_carry);
    endtask

    task automatic test_carry();
        do_reset();
        set_op(1, 8'hF6, 8'h0A, 4'h0);
        req_valid = 2'b10;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("FAIL carry_ready got=%b exp=10", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b10 || rsp_data !== 8'h00 || rsp_carry !== 1'b1) begin
            failures++;
            $display("FAIL carry_resp rv=%b d=%h c=%b exp rv=10 d=00 c=1", rsp_valid, rsp_data, rsp_carry);
        end
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
        $display("test_carry: f6+0a -> d=%h c=%b", rsp_data, rsp_carry);
    endtask

    task automatic test_contention();
        logic [1:0] exp_rr;
        int grant_no = 0;
        do_reset();
        set_op(0, 8'h10, 8'h01, 4'h0);
        set_op(1, 8'h20, 8'h02, 4'h1);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_rr = 2'b00;
            if (c % 3 == 0) exp_rr = (grant_no % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (req_ready !== exp_rr) begin
                failures++;
                $display("FAIL contention_grant cycle=%0d got=%b exp=%b", c, req_ready, exp_rr);
            end
            if (c % 3 == 2) begin
                checks++;
                if (rsp_data !== ((grant_no % 2 == 0) ? 8'h11 : 8'h1E)) begin
                    failures++;
                    $display("FAIL contention_data cycle=%0d got=%h", c, rsp_data);
                end
                grant_no++;
            end
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick(); tick(); tick();
        $display("test_contention: %0d grants checked", grant_no);
    endtask

    task automatic test_backpressure();
        do_reset();
        set_op(0, 8'h30, 8'h05, 4'h1);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        set_op(1, 8'h01, 8'h01, 4'h0);
        rsp_ready = 2'b10;
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 2'b01 || rsp_data !== 8'h2B || rsp_carry !== 1'b0 || busy !== 1'b1 || req_ready !== 2'b00) begin
                failures++;
                $display("FAIL backpressure_hold cycle=%0d rv=%b d=%h c=%b busy=%b rr=%b exp rv=01 d=2b c=0 busy=1 rr=00",
                         c, rsp_valid, rsp_data, rsp_carry, busy, req_ready);
            end
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
            failures++;
            $display("FAIL backpressure_release busy=%b rv=%b rr=%b exp busy=0 rv=00 rr=10", busy, rsp_valid, req_ready);
        end
        #2;
        req_valid = 2'b00;
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL backpressure_withdraw busy=%b exp=0", busy); end
        tick();
        $display("test_backpressure: hold and release checked");
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_op(0, 8'h44, 8'h11, 4'h0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_carry, busy, alu_a, alu_b, alu_sel} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs rr=%b rv=%b d=%h c=%b busy=%b a=%h b=%h s=%h expected all 0",
                     req_ready, rsp_valid, rsp_data, rsp_carry, busy, alu_a, alu_b, alu_sel);
        end
        rsp_ready = 2'b11;
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            checks++;
            if (rsp_valid !== 2'b00) begin
                failures++;
                $display("FAIL reset_mid_no_rsp cycle=%0d rv=%b exp=00", c, rsp_valid);
            end
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL reset_mid_ptr rr=%b exp=01", req_ready); end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();
        $display("test_reset_mid: abort checked");
    endtask

    task automatic test_withdrawn();
        do_reset();
        set_op(0, 8'h02, 8'h03, 4'h0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 2'b00) begin
                failures++;
                $display("FAIL withdrawn_ready cycle=%0d rr=%b exp=00", c, req_ready);
            end
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 2'b00 || busy !== 1'b0) begin
                failures++;
                $display("FAIL withdrawn_idle cycle=%0d rr=%b busy=%b exp rr=00 busy=0", c, req_ready, busy);
            end
            tick();
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("FAIL withdrawn_ptr rr=%b exp=10", req_ready); end
        req_valid = 2'b00;
        tick();
        $display("test_withdrawn: no grant to withdrawn requester");
    endtask

    // Transaction-level model: an outstanding op blocks new grants; its result appears
    // two cycles after the accept on the owner's bit and stays until the owner takes it.
    task automatic test_random();
        bit         pend = 0;
        int         age = 0;
        int         owner = 0;
        bit         last_winner = 1;
        logic [8:0] expv = '0;
        logic [1:0] exp_rr, exp_rv;
        logic [7:0] ra [2];
        logic [7:0] rb [2];
        logic [3:0] rs [2];
        int         ops = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                ra[i] = 8'($urandom);
                rb[i] = 8'($urandom);
                rs[i] = 4'($urandom_range(0, 1));
                set_op(i, ra[i], rb[i], rs[i]);
            end
            @(negedge clk);
            exp_rr = 2'b00;
            if (!pend) begin
                if (req_valid == 2'b11) exp_rr = last_winner ? 2'b01 : 2'b10;
                else                    exp_rr = req_valid;
            end
            exp_rv = (pend && age >= 2) ? (owner == 1 ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if (req_ready !== exp_rr || busy !== pend || rsp_valid !== exp_rv) begin
                failures++;
                $display("FAIL random_ctrl cycle=%0d rr=%b busy=%b rv=%b exp rr=%b busy=%b rv=%b",
                         c, req_ready, busy, rsp_valid, exp_rr, pend, exp_rv);
            end
            if (exp_rv != 2'b00) begin
                checks++;
                if (rsp_data !== expv[7:0] || rsp_carry !== expv[8]) begin
                    failures++;
                    $display("FAIL random_data cycle=%0d d=%h c=%b exp d=%h c=%b",
                             c, rsp_data, rsp_carry, expv[7:0], expv[8]);
                end
            end
            if (pend && age >= 2 && rsp_ready[owner]) begin
                pend = 0;
                ops++;
            end else if (pend) begin
                age++;
            end else if (exp_rr != 2'b00) begin
                owner       = exp_rr[1] ? 1 : 0;
                last_winner = exp_rr[1];
                expv        = alu_f(ra[owner], rb[owner], rs[owner]);
                pend        = 1;
                age         = 1;
            end
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        $display("test_random: %0d responses completed", ops);
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_withdrawn();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
